// File: rtl/fp_div_seq_if.sv
// ============================================================================
// Module   : fp_div_seq_if
// Purpose  : Operand/result handshake bundle for the sequential FP divider.
//            The master side is the operand producer and result consumer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fp_div_seq_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) ();

  localparam int W = 1 + EXP_W + MAN_W;

  logic         i_Valid;
  logic         o_Ready;
  logic [W-1:0] i_Dividend;
  logic [W-1:0] i_Divisor;
  logic         o_Valid;
  logic         i_Ready;
  logic [W-1:0] o_Quotient;
  logic [3:0]   o_Flags;
  logic         o_Exception;

  // Divider side
  modport slave (
    input  i_Valid, i_Dividend, i_Divisor, i_Ready,
    output o_Ready, o_Valid, o_Quotient, o_Flags, o_Exception
  );

  // Producer / consumer side
  modport master (
    output i_Valid, i_Dividend, i_Divisor, i_Ready,
    input  o_Ready, o_Valid, o_Quotient, o_Flags, o_Exception
  );

endinterface

`default_nettype wire

// File: rtl/fp_div_seq.sv
// ============================================================================
// Module   : fp_div_seq
// Purpose  : Sequential IEEE-style floating-point divider. Restoring radix-2
//            mantissa division, one quotient bit per cycle, truncating result.
//            Subnormals are flushed to zero; specials resolve in one cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_div_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic        i_Clk,
  input  logic        i_Reset_n,
  fp_div_seq_if.slave bus
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int CNT_W = $clog2(MAN_W + 3);
  localparam int XW    = EXP_W + 2;

  localparam logic signed [XW-1:0] BIAS    = XW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((2 ** EXP_W) - 1);
  localparam logic [CNT_W-1:0]     LAST_IT = CNT_W'(MAN_W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_NORM   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [W-2:0] INF_BODY  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-2:0] ZERO_BODY = '0;
  localparam logic [W-1:0] QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [1:0] state;
  logic [1:0] state_next;

  // ---------------------------------------------------------------------------
  // Operand field decode (only meaningful on the accept edge)
  // ---------------------------------------------------------------------------
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic             a_zero, a_inf, a_nan;
  logic             b_zero, b_inf, b_nan;
  logic             in_sign;

  assign a_sign  = bus.i_Dividend[W-1];
  assign a_exp   = bus.i_Dividend[W-2:MAN_W];
  assign a_frac  = bus.i_Dividend[MAN_W-1:0];
  assign b_sign  = bus.i_Divisor[W-1];
  assign b_exp   = bus.i_Divisor[W-2:MAN_W];
  assign b_frac  = bus.i_Divisor[MAN_W-1:0];
  assign in_sign = a_sign ^ b_sign;

  // Exponent 0 is treated as zero regardless of fraction (flush-to-zero)
  assign a_zero = (a_exp == '0);
  assign a_inf  = (&a_exp) && (a_frac == '0);
  assign a_nan  = (&a_exp) && (a_frac != '0);
  assign b_zero = (b_exp == '0);
  assign b_inf  = (&b_exp) && (b_frac == '0);
  assign b_nan  = (&b_exp) && (b_frac != '0);

  logic         accept;
  logic         special;
  logic [W-1:0] sp_quot;
  logic [3:0]   sp_flags;

  assign accept = bus.i_Valid && (state == S_IDLE);

  // Resolve special operand combinations; priority order matters (NaN first)
  always_comb begin
    special  = 1'b1;
    sp_quot  = '0;
    sp_flags = 4'b0000;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      sp_quot  = QNAN;
      sp_flags = 4'b1000;
    end else if (a_inf) begin
      sp_quot = {in_sign, INF_BODY};
    end else if (b_inf) begin
      sp_quot = {in_sign, ZERO_BODY};
    end else if (b_zero) begin
      sp_quot  = {in_sign, INF_BODY};
      sp_flags = 4'b0100;
    end else if (a_zero) begin
      sp_quot = {in_sign, ZERO_BODY};
    end else begin
      special = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic                 res_sign;
  logic signed [XW-1:0] exp_q;
  logic [MAN_W+1:0]     rem;
  logic [MAN_W:0]       divisor_m;
  logic [MAN_W+1:0]     quo;
  logic [CNT_W-1:0]     cnt;
  logic [W-1:0]         quot_q;
  logic [3:0]           flags_q;

  // One restoring step: subtract if it fits, then shift the partial remainder
  logic             rem_ge;
  logic [MAN_W+1:0] rem_diff;
  logic [MAN_W+1:0] rem_sel;

  always_comb begin
    rem_ge   = (rem >= {1'b0, divisor_m});
    rem_diff = rem - {1'b0, divisor_m};
    rem_sel  = rem_ge ? rem_diff : rem;
  end

  // Normalisation: the quotient lies in [0.5, 2), so at most one left shift
  logic                 q_msb;
  logic signed [XW-1:0] exp_n;
  logic [MAN_W-1:0]     frac_n;
  logic                 ovf;
  logic                 unf;
  logic [W-1:0]         norm_quot;
  logic [3:0]           norm_flags;

  always_comb begin
    q_msb  = quo[MAN_W+1];
    exp_n  = q_msb ? exp_q : (exp_q - XW'(1));
    frac_n = q_msb ? quo[MAN_W:1] : quo[MAN_W-1:0];
    ovf    = (exp_n >= EXP_MAX);
    unf    = !ovf && (exp_n[XW-1] || (exp_n == '0));
    if (ovf) begin
      norm_quot = {res_sign, INF_BODY};
    end else if (unf) begin
      norm_quot = {res_sign, ZERO_BODY};
    end else begin
      norm_quot = {res_sign, exp_n[EXP_W-1:0], frac_n};
    end
    norm_flags = {2'b00, ovf, unf};
  end

  // State register
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = special ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (cnt == LAST_IT) state_next = S_NORM;
      S_NORM:   state_next = S_DONE;
      S_DONE:   if (bus.i_Ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.o_Ready = (state == S_IDLE);
    bus.o_Valid = (state == S_DONE);
  end

  // Datapath: capture, iterate, normalise, present and clear the result
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      res_sign  <= 1'b0;
      exp_q     <= '0;
      rem       <= '0;
      divisor_m <= '0;
      quo       <= '0;
      cnt       <= '0;
      quot_q    <= '0;
      flags_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            res_sign  <= in_sign;
            exp_q     <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS;
            rem       <= {1'b0, 1'b1, a_frac};
            divisor_m <= {1'b1, b_frac};
            quo       <= '0;
            cnt       <= '0;
            if (special) begin
              quot_q  <= sp_quot;
              flags_q <= sp_flags;
            end
          end
        end
        S_DIVIDE: begin
          rem <= {rem_sel[MAN_W:0], 1'b0};
          quo <= {quo[MAN_W:0], rem_ge};
          cnt <= cnt + 1'b1;
        end
        S_NORM: begin
          quo     <= q_msb ? quo : {quo[MAN_W:0], 1'b0};
          exp_q   <= exp_n;
          quot_q  <= norm_quot;
          flags_q <= norm_flags;
        end
        S_DONE: begin
          if (bus.i_Ready) begin
            quot_q  <= '0;
            flags_q <= '0;
          end
        end
        default: begin
          quot_q  <= '0;
          flags_q <= '0;
        end
      endcase
    end
  end

  assign bus.o_Quotient  = quot_q;
  assign bus.o_Flags     = flags_q;
  assign bus.o_Exception = |flags_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_div_seq.sv
// ============================================================================
// Module   : tb_fp_div_seq
// Purpose  : Self-checking bench for fp_div_seq (half-precision defaults).
//            Expected results are queued when an operand pair is driven and
//            compared when the divider presents its result.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_div_seq;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int NLAT  = MAN_W + 3;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic [W+3:0] sb_q[$];
  int           lat_q[$];

  fp_div_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_div_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .i_Clk     (clk),
    .i_Reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one operand pair, then wait for and score its result.
  // elat counts clock edges after the accept edge until o_Valid is seen.
  // hold > 0 keeps i_Ready low for that many cycles in DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [3:0] ef,
                        input int elat, input int hold);
    int           lat;
    logic [W+3:0] exp_e;
    int           exp_l;
    @(negedge clk);
    check("ready_before_accept", bus.o_Ready, 1'b1);
    bus.i_Valid    = 1'b1;
    bus.i_Dividend = a;
    bus.i_Divisor  = b;
    bus.i_Ready    = (hold == 0);
    sb_q.push_back({eq, ef});
    lat_q.push_back(elat);
    @(posedge clk);
    #1;
    // Scramble operands after accept; the result must not change
    bus.i_Valid    = 1'b0;
    bus.i_Dividend = ~a;
    bus.i_Divisor  = ~b;
    lat = 0;
    while (!bus.o_Valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    exp_e = sb_q.pop_front();
    exp_l = lat_q.pop_front();
    check("latency", lat, exp_l);
    check("quotient", bus.o_Quotient, exp_e[W+3:4]);
    check("flags", bus.o_Flags, exp_e[3:0]);
    check("exception", bus.o_Exception, |exp_e[3:0]);
    check("ready_in_done", bus.o_Ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      bus.i_Valid    = 1'b1;
      bus.i_Dividend = W'($urandom);
      bus.i_Divisor  = W'($urandom);
      @(posedge clk);
      #1;
      check("hold_valid", bus.o_Valid, 1'b1);
      check("hold_ready", bus.o_Ready, 1'b0);
      check("hold_quotient", bus.o_Quotient, exp_e[W+3:4]);
      check("hold_flags", bus.o_Flags, exp_e[3:0]);
    end
    bus.i_Valid = 1'b0;
    bus.i_Ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_after_consume", bus.o_Valid, 1'b0);
    check("ready_after_consume", bus.o_Ready, 1'b1);
    check("quotient_cleared", bus.o_Quotient, '0);
    check("flags_cleared", bus.o_Flags, 4'b0000);
  endtask

  initial begin : stim
    bit seen;
    rst_n          = 1'b0;
    bus.i_Valid    = 1'b0;
    bus.i_Dividend = '0;
    bus.i_Divisor  = '0;
    bus.i_Ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", bus.o_Ready, 1'b1);
    check("reset_valid", bus.o_Valid, 1'b0);
    check("reset_quotient", bus.o_Quotient, '0);
    check("reset_flags", bus.o_Flags, 4'b0000);
    rst_n = 1'b1;

    // Normal divisions
    run_op(16'h3E00, 16'h3800, 16'h4200, 4'b0000, NLAT, 0); // 1.5 / 0.5
    run_op(16'h3C00, 16'h4200, 16'h3555, 4'b0000, NLAT, 0); // 1 / 3
    run_op(16'hBC00, 16'h4200, 16'hB555, 4'b0000, NLAT, 0); // -1 / 3
    run_op(16'h4200, 16'h4000, 16'h3E00, 4'b0000, NLAT, 0); // 3 / 2
    run_op(16'hBE00, 16'hB800, 16'h4200, 4'b0000, NLAT, 0); // -1.5 / -0.5
    run_op(16'h4000, 16'h3C00, 16'h4000, 4'b0000, NLAT, 0); // 2 / 1

    // Range limits
    run_op(16'h7BFF, 16'h1400, 16'h7C00, 4'b0010, NLAT, 0); // overflow
    run_op(16'h0400, 16'h7800, 16'h0000, 4'b0001, NLAT, 0); // underflow

    // Special operands resolve on the accept edge
    run_op(16'h3C00, 16'h0000, 16'h7C00, 4'b0100, 0, 0);    // x / 0
    run_op(16'h4000, 16'h8000, 16'hFC00, 4'b0100, 0, 0);    // x / -0
    run_op(16'h0000, 16'h0000, 16'h7E00, 4'b1000, 0, 0);    // 0 / 0
    run_op(16'h7C00, 16'hFC00, 16'h7E00, 4'b1000, 0, 0);    // Inf / -Inf
    run_op(16'h7E01, 16'h3C00, 16'h7E00, 4'b1000, 0, 0);    // NaN / x
    run_op(16'h7C00, 16'h4000, 16'h7C00, 4'b0000, 0, 0);    // Inf / x
    run_op(16'h4000, 16'hFC00, 16'h8000, 4'b0000, 0, 0);    // x / -Inf
    run_op(16'h0000, 16'hC000, 16'h8000, 4'b0000, 0, 0);    // 0 / -2
    run_op(16'h0123, 16'h3C00, 16'h0000, 4'b0000, 0, 0);    // subnormal flushed

    // Back-pressure: result held for 20 cycles while new operands are offered
    run_op(16'h3C00, 16'h4200, 16'h3555, 4'b0000, NLAT, 20);

    // Reset in the middle of the divide aborts the operation
    @(negedge clk);
    bus.i_Valid    = 1'b1;
    bus.i_Dividend = 16'h3E00;
    bus.i_Divisor  = 16'h3800;
    bus.i_Ready    = 1'b1;
    @(posedge clk);
    #1;
    bus.i_Valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("ready_mid_divide", bus.o_Ready, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_ready", bus.o_Ready, 1'b1);
    check("abort_valid", bus.o_Valid, 1'b0);
    check("abort_quotient", bus.o_Quotient, '0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.o_Valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 1'b0);
    check("abort_ready_idle", bus.o_Ready, 1'b1);

    // Divider still operates normally after the abort
    run_op(16'h3E00, 16'h3800, 16'h4200, 4'b0000, NLAT, 0);

    check("scoreboard_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
